// File: rtl/mul16_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mul_pkg
// Description : Shared widths, state encoding and helpers for mul16_seq.
//               Optional feature macro: MUL16_SIGNED_EN (see mul16_seq).
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  localparam int HALF_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef logic [2*HALF_W-1:0] mul_op_t;
  typedef logic [4*HALF_W-1:0] mul_res_t;

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is exactly its magnitude when read back as unsigned.
  function automatic mul_op_t mag(input mul_op_t v);
    return v[2*HALF_W-1] ? mul_op_t'(-v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul16_seq_if.sv
`default_nettype none
// ============================================================================
// Interface   : mul16_seq_if
// Description : Operand/product handshake bundle for mul16_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul16_seq_if;
  import mul_pkg::*;

  logic     in_valid;
  logic     in_ready;
  mul_op_t  op_a;
  mul_op_t  op_b;
  logic     out_valid;
  logic     out_ready;
  mul_res_t product;
  logic     busy;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface
`default_nettype wire

// File: rtl/mul16_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : mul8_core
// Description : Unsigned W x W combinational multiplier, 2W-bit product.
// Revision    : 1.0 - initial release
// ============================================================================
module mul8_core #(
  parameter int W = 8
) (
  input  wire logic [W-1:0]   i_a,
  input  wire logic [W-1:0]   i_b,
  output logic      [2*W-1:0] o_p
);
  assign o_p = (2*W)'(i_a) * (2*W)'(i_b);
endmodule
`default_nettype wire

// File: rtl/mul16_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul16_seq
// Description : 16x16->32 multiply built from four passes through one 8x8
//               core. Macro MUL16_SIGNED_EN enables two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
module mul16_seq
  import mul_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    rst,
  mul16_seq_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_MUL  = 2'(MUL);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]          r_state;
  logic [1:0]          r_step;
  mul_op_t             r_a;
  mul_op_t             r_b;
  mul_res_t            r_acc;
  mul_res_t            r_product;

  logic [HALF_W-1:0]   w_core_a;
  logic [HALF_W-1:0]   w_core_b;
  logic [2*HALF_W-1:0] w_core_p;
  logic [4:0]          w_shift;
  mul_res_t            w_term;
  mul_res_t            w_sum;
  mul_res_t            w_result;
  mul_op_t             w_lat_a;
  mul_op_t             w_lat_b;

  // step[0] picks the high byte of a, step[1] the high byte of b
  assign w_core_a = r_step[0] ? r_a[2*HALF_W-1:HALF_W] : r_a[HALF_W-1:0];
  assign w_core_b = r_step[1] ? r_b[2*HALF_W-1:HALF_W] : r_b[HALF_W-1:0];

  mul8_core #(.W(HALF_W)) u_core (
    .i_a (w_core_a),
    .i_b (w_core_b),
    .o_p (w_core_p)
  );

  // Byte weight of the partial product: 0, 8, 8, 16 for steps 0..3
  assign w_shift = {&r_step, ^r_step, 3'b000};
  assign w_term  = mul_res_t'(w_core_p) << w_shift;
  assign w_sum   = r_acc + w_term;

`ifdef MUL16_SIGNED_EN
  logic r_neg;

  assign w_lat_a  = mag(bus.op_a);
  assign w_lat_b  = mag(bus.op_b);
  assign w_result = r_neg ? mul_res_t'(-w_sum) : w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (r_state == S_IDLE && bus.in_valid) begin
      r_neg <= bus.op_a[2*HALF_W-1] ^ bus.op_b[2*HALF_W-1];
    end
  end
`else
  assign w_lat_a  = bus.op_a;
  assign w_lat_b  = bus.op_b;
  assign w_result = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_step    <= 2'd0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= w_lat_a;
            r_b     <= w_lat_b;
            r_acc   <= '0;
            r_step  <= 2'd0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc  <= w_sum;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_product <= w_result;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_MUL) || (r_state == S_DONE);
  assign bus.product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mul16_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul16_seq
// Description : Self-checking bench for mul16_seq (honours MUL16_SIGNED_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul16_seq;
  import mul_pkg::*;

  localparam int N_OPS     = 3000;
  localparam int CYC_LIMIT = 60000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mul16_seq_if bus ();

  mul16_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic mul_res_t ref_mul(input mul_op_t a, input mul_op_t b);
`ifdef MUL16_SIGNED_EN
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return mul_res_t'(p);
`else
    return mul_res_t'(a) * mul_res_t'(b);
`endif
  endfunction

  // Accept one pair from IDLE and check the product appears exactly on the
  // 5th edge counting the accept edge as the first.
  task automatic issue_and_wait(input string tag, input mul_op_t a, input mul_op_t b);
    @(negedge clk);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a     = mul_op_t'($urandom);
    bus.op_b     = mul_op_t'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_ov"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input mul_op_t a, input mul_op_t b,
                        input mul_res_t exp);
    issue_and_wait(tag, a, b);
    chk({tag, "_prod"}, bus.product, exp);
    release_result(tag);
  endtask

  initial begin
    mul_res_t q[$];
    int       issued;
    int       cyc;
    mul_op_t  ra;
    mul_op_t  rb;

    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_product", bus.product, 32'd0);
    rst = 1'b0;

    run_op("d1234", 16'h1234, 16'h5678, 32'h06260060);
`ifdef MUL16_SIGNED_EN
    run_op("dffff", 16'hFFFF, 16'hFFFF, 32'h00000001);
    run_op("dneg2", 16'hFFFF, 16'h0002, 32'hFFFFFFFE);
`else
    run_op("dffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op("dneg2", 16'hFFFF, 16'h0002, 32'h0001FFFE);
`endif
    run_op("dzero", 16'h0000, 16'hABCD, 32'h00000000);
    run_op("d8000", 16'h8000, 16'h8000, 32'h40000000);

    // Held result under backpressure while a new pair is offered
    issue_and_wait("bp", 16'h00FF, 16'h0101);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a     = 16'h0007;
    bus.op_b     = 16'h0009;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ov", 32'(bus.out_valid), 32'd1);
      chk("bp_prod", bus.product, 32'h0000FFFF);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    release_result("bp");
    @(negedge clk);
    chk("bp_no_accept", 32'(bus.busy), 32'd0);

    // Reset while step 2 is in flight
    @(negedge clk);
    bus.op_a     = 16'hFFFF;
    bus.op_b     = 16'hFFFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ov", 32'(bus.out_valid), 32'd0);
    chk("mrst_rdy", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst_no_pulse", 32'(bus.out_valid), 32'd0);
    end
    run_op("mrst_next", 16'h0003, 16'h0005, 32'h0000000F);

    // Random traffic against the arithmetic reference and an in-order queue
    issued = 0;
    cyc    = 0;
    while ((issued < N_OPS || q.size() != 0) && cyc < CYC_LIMIT) begin
      @(negedge clk);
      cyc++;
      case ($urandom_range(5))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h8000;
        2:       ra = 16'h0000;
        default: ra = mul_op_t'($urandom);
      endcase
      case ($urandom_range(5))
        0:       rb = 16'hFFFF;
        1:       rb = 16'h8000;
        2:       rb = 16'h0001;
        default: rb = mul_op_t'($urandom);
      endcase
      bus.op_a      = ra;
      bus.op_b      = rb;
      bus.in_valid  = (issued < N_OPS) && ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) != 0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_mul(ra, rb));
        issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("rand_dup", 32'd1, 32'd0);
        else               chk("rand_prod", bus.product, q.pop_front());
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("rand_timeout", 32'(cyc < CYC_LIMIT), 32'd1);
    chk("rand_issued", 32'(issued), 32'(N_OPS));
    chk("rand_drain", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
